// File: rtl/fifo_dot_acc_pkg.sv
// fifo_dot_acc_pkg: shared types and default sizing for the operand-FIFO
// dot-product accumulator.
//   state_e        - controller state (IDLE / RUN / DONE)
//   *_DEF          - default parameter values used by fifo_dot_acc
package fifo_dot_acc_pkg;

  localparam int unsigned D_WIDTH_DEF   = 4;
  localparam int unsigned LEN_W_DEF     = 8;
  localparam int unsigned ACC_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/dot_mac_unit.sv
// dot_mac_unit: combinational signed multiply-add for one operand pair.
//   acc_i  - current accumulator value (signed, ACC_WIDTH)
//   pair_i - packed pair, a = upper D_WIDTH bits, b = lower D_WIDTH bits
//   sum_o  - acc_i + sext(a*b), saturated or wrapped
//   ovf_o  - the add was clamped (only with FIFO_DOT_ACC_SAT_EN)
// Build option: FIFO_DOT_ACC_SAT_EN selects saturating adds; otherwise the
// add wraps in two's complement and ovf_o is absent.
module dot_mac_unit #(
  parameter int unsigned D_WIDTH   = 4,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  input  logic [2*D_WIDTH-1:0] pair_i,
  output logic [ACC_WIDTH-1:0] sum_o
`ifdef FIFO_DOT_ACC_SAT_EN
  ,
  output logic                 ovf_o
`endif
);

  logic signed [D_WIDTH-1:0]   op_a;
  logic signed [D_WIDTH-1:0]   op_b;
  logic signed [2*D_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] prod_x;

  assign op_a   = pair_i[2*D_WIDTH-1:D_WIDTH];
  assign op_b   = pair_i[D_WIDTH-1:0];
  assign prod   = op_a * op_b;
  assign prod_x = prod;  // signed-to-signed assignment sign-extends

`ifdef FIFO_DOT_ACC_SAT_EN
  // One guard bit: overflow shows up as disagreement of the top two bits.
  logic signed [ACC_WIDTH:0]   wide;
  logic signed [ACC_WIDTH-1:0] pos_max;
  logic signed [ACC_WIDTH-1:0] neg_min;

  assign pos_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  assign neg_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  assign wide    = {acc_i[ACC_WIDTH-1], acc_i} + {prod_x[ACC_WIDTH-1], prod_x};

  always_comb begin
    ovf_o = (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]);
    sum_o = wide[ACC_WIDTH-1:0];
    if (ovf_o) begin
      sum_o = wide[ACC_WIDTH] ? neg_min : pos_max;
    end
  end
`else
  assign sum_o = acc_i + prod_x;
`endif

endmodule

// File: rtl/fifo_dot_acc.sv
// fifo_dot_acc: drains signed operand pairs from an upstream FIFO and
// accumulates their dot product over a programmed vector length, then offers
// the result on a valid/ready port.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, vec_len      - command strobe and element count (IDLE only)
//   abort               - abandon the current command, result discarded
//   busy                - controller not idle
//   fifo_empty/dout/pop - FIFO read side; dout is sampled in the pop cycle
//   res_valid/ready     - result handshake
//   res_data            - accumulated result
//   res_ovf             - sticky clamp flag (only with FIFO_DOT_ACC_SAT_EN)
// Build option: FIFO_DOT_ACC_SAT_EN enables saturating accumulation and the
// res_ovf port; without it the accumulator wraps.
module fifo_dot_acc
  import fifo_dot_acc_pkg::*;
#(
  parameter int unsigned D_WIDTH   = D_WIDTH_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     vec_len,
  input  logic                 abort,
  output logic                 busy,
  input  logic                 fifo_empty,
  input  logic [2*D_WIDTH-1:0] fifo_dout,
  output logic                 fifo_pop,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res_data
`ifdef FIFO_DOT_ACC_SAT_EN
  ,
  output logic                 res_ovf
`endif
);

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   mac_sum;
`ifdef FIFO_DOT_ACC_SAT_EN
  logic                   ovf_q, ovf_d;
  logic                   mac_ovf;
`endif

  dot_mac_unit #(
    .D_WIDTH   (D_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .acc_i  (acc_q),
    .pair_i (fifo_dout),
    .sum_o  (mac_sum)
`ifdef FIFO_DOT_ACC_SAT_EN
    ,
    .ovf_o  (mac_ovf)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef FIFO_DOT_ACC_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef FIFO_DOT_ACC_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Pop is gated by empty and abort so no read is ever issued into an empty
  // FIFO and an aborted cycle consumes nothing.
  assign fifo_pop = (state_q == ST_RUN) & ~fifo_empty & ~abort;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef FIFO_DOT_ACC_SAT_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
`ifdef FIFO_DOT_ACC_SAT_EN
          ovf_d = 1'b0;
`endif
          if (vec_len != '0) begin
            cnt_d   = vec_len;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fifo_pop) begin
          acc_d = mac_sum;
          cnt_d = cnt_q - LEN_W'(1);
`ifdef FIFO_DOT_ACC_SAT_EN
          ovf_d = ovf_q | mac_ovf;
`endif
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (abort || res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = acc_q;
`ifdef FIFO_DOT_ACC_SAT_EN
  assign res_ovf   = ovf_q;
`endif

endmodule

// File: doc/fifo_dot_acc.md
# fifo_dot_acc

Downstream consumer of the accelerator's operand FIFO. It drains packed signed operand pairs, accumulates a signed dot product over a programmed vector length, and presents the result on a valid/ready port to the accumulator writeback stage. The FIFO's data output is valid combinationally in the same cycle its pop strobe is asserted while it is non-empty, so this block samples `fifo_dout` in the cycle it pops.

## Interface
- `D_WIDTH`, default 4: signed width of each operand. The upstream FIFO is instantiated with data width 2*D_WIDTH.
- `LEN_W`, default 8: width of the vector-length field.
- `ACC_WIDTH`, default 16: signed accumulator and result width. Must be ≥ 2*D_WIDTH.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: command strobe. Honoured only in IDLE.
- `vec_len`, in, LEN_W: number of operand pairs. Sampled when `start` is accepted.
- `abort`, in, 1: synchronous abandon of the current command.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `fifo_empty`, in, 1: empty flag from the FIFO.
- `fifo_dout`, in, 2*D_WIDTH: packed pair. `a` = [2*D_WIDTH-1:D_WIDTH], `b` = [D_WIDTH-1:0].
- `fifo_pop`, out, 1: pop strobe to the FIFO.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts the result.
- `res_data`, out, ACC_WIDTH: dot-product result.
- `res_ovf`, out, 1: sticky overflow flag. Exists only with `FIFO_DOT_ACC_SAT_EN`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start` with `vec_len` ≠ 0: acc←0, cnt←`vec_len`, ovf←0, go to RUN.
  - `start` with `vec_len` = 0: acc←0, go directly to DONE.
- **RUN:**
  - `fifo_pop` = (state==RUN) & !`fifo_empty` & !`abort`. This is combinational; no pop is ever issued into an empty FIFO.
  - On each pop: acc ← acc + sext(a)·sext(b), cnt ← cnt−1.
  - If cnt was 1, go to DONE.
  - While `fifo_empty` is high: stall, holding acc and cnt.
- **DONE:**
  - `res_valid` = 1 and `res_data` = acc. Both are held stable until `res_ready` is seen.
  - On `res_valid` & `res_ready`: go to IDLE.
- **`start` outside IDLE** is ignored; it is not queued.
- **`abort`** in RUN or DONE: go to IDLE next cycle, no pop that cycle, result discarded. `abort` has priority over every other transition.
- **Arithmetic:**
  - Each product is a 2*D_WIDTH-bit signed value, sign-extended to ACC_WIDTH before the add.
  - Overflow handling is set by `FIFO_DOT_ACC_SAT_EN` (see Configuration).
- **Reset** (asynchronous, any state, including mid-vector): state=IDLE, acc=0, cnt=0, `busy`=0, `fifo_pop`=0, `res_valid`=0, `res_data`=0, `res_ovf`=0. Elements already popped are lost; the FIFO is reset by the same `rst_n`.

## Timing
- `start` is accepted in cycle 0. RUN occupies cycles 1..N when the FIFO never empties, and `res_valid` rises in cycle N+1.
- Each empty stall cycle adds one cycle of latency.
- With `vec_len` = 0, `res_valid` rises in cycle 1.
- Throughput: one element per cycle. Back-to-back commands need one IDLE cycle between DONE and the next `start`.
- `res_ready` may be held high in advance; the handshake then completes in the first DONE cycle.
- The multiply-add is single-cycle, combinational from `fifo_dout` into the acc register.

## Configuration
- **Macro:** `FIFO_DOT_ACC_SAT_EN`.
- **Defined:**
  - Every add saturates to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
  - `res_ovf` is set sticky whenever a clamp occurs, is cleared on command accept, and is valid alongside `res_data`.
- **Undefined:** two's-complement wrap, and the `res_ovf` port is absent.

## Structure
- **Package `fifo_dot_acc_pkg`:** state enum (IDLE/RUN/DONE) and default parameter constants (D_WIDTH, LEN_W, ACC_WIDTH).
- **Sub-module `dot_mac_unit`:** combinational sext-multiply-add with the saturate/wrap selection and an overflow indication. The top level holds the FSM, counter and registers.

## Test plan
All scenarios use D_WIDTH=4.

1. **Basic dot product** (ACC_WIDTH=16): vec_len=4, pairs (3,2),(−4,5),(7,7),(−8,−8) preloaded → exactly 4 pops, `res_data`=99 with `res_valid` in cycle 5.
2. **Empty stalls:** same data with the FIFO empty for 3 cycles mid-vector → `fifo_pop` is never high while empty, result 99 in cycle 8.
3. **Zero length and backpressure:** vec_len=0 → `res_valid` in cycle 1 with `res_data`=0. Then hold `res_ready`=0 for 5 cycles → data stable, `busy`=1; a `start` issued in DONE is ignored.
4. **Overflow** (ACC_WIDTH=8): (7,7) three times → with the macro, `res_data`=127 and `res_ovf`=1; without it, `res_data`=−109.
5. **Abort:** `abort` after 2 of 4 pops → IDLE next cycle, no `res_valid`, 2 elements remain in the FIFO. A following vec_len=2 command → 8·8 product sum matches the remaining data.
6. **Async reset:** assert `rst_n`=0 mid-RUN between clock edges → all outputs 0 immediately; the next command operates normally.
